axis_red_pitaya_adc_capture: RTL and testbench

- Receive-side counterpart of the DAC/PRBS transmitter: registers both Red Pitaya ADC channels and converts the ADC's inverted-magnitude code to two's complement.
- Captures a frame of N sample pairs, started by the transmitter's sequence flag, and emits it on an AXI4-Stream master with tlast on the final sample.
- A small FIFO absorbs downstream back-pressure; the ADC cannot be stalled, so overflow drops samples and raises a sticky flag.

---
 rtl/axis_red_pitaya_adc_capture.sv | 215 +++++++++++++++++++++
 tb/tb_axis_red_pitaya_adc_capture.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_red_pitaya_adc_capture.sv
// Red Pitaya ADC receive path: code conversion, triggered frame capture,
// FIFO-buffered AXI4-Stream output with sticky overflow on dropped samples.
module axis_red_pitaya_adc_capture #(
    parameter int ADC_DATA_WIDTH   = 14,
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int FRAME_LEN_WIDTH  = 16,
    parameter int FIFO_DEPTH       = 16
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [ADC_DATA_WIDTH-1:0]   adc_dat_a,
    input  logic [ADC_DATA_WIDTH-1:0]   adc_dat_b,
    output logic                        adc_csn,
    input  logic                        sync_flag_i,
    input  logic [31:0]                 rx_cfg_i,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic [3:0]                  rx_status_o
);

    localparam int HW = AXIS_TDATA_WIDTH / 2;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int FLW = FRAME_LEN_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_CAPT,
        S_DONE
    } state_t;

    function automatic logic [HW-1:0] f_conv(
        input logic [ADC_DATA_WIDTH-1:0] raw
    );
        logic [ADC_DATA_WIDTH-1:0] v;
        v = {raw[ADC_DATA_WIDTH-1], ~raw[ADC_DATA_WIDTH-2:0]};
        return {{(HW-ADC_DATA_WIDTH){v[ADC_DATA_WIDTH-1]}}, v};
    endfunction

    logic [FLW-1:0] w_len;
    logic [FLW-1:0] w_last_idx;
    logic           w_arm;
    logic           w_mode;
    logic           w_srst;
    logic           w_unused_cfg;

    assign w_len        = rx_cfg_i[FLW-1:0];
    assign w_last_idx   = w_len - FLW'(1);
    assign w_arm        = rx_cfg_i[16];
    assign w_mode       = rx_cfg_i[17];
    assign w_srst       = rx_cfg_i[18];
    assign w_unused_cfg = ^rx_cfg_i[31:19];

    state_t                      r_state;
    logic [FLW-1:0]              r_cnt;
    logic                        r_arm_q;
    logic                        r_rise;
    logic [ADC_DATA_WIDTH-1:0]   r_s1_a;
    logic [ADC_DATA_WIDTH-1:0]   r_s1_b;
    logic [AXIS_TDATA_WIDTH-1:0] r_s2;

    logic w_trig;
    logic w_wr;
    logic w_last;

    always_comb begin
        w_trig = (r_state == S_ARMED) && w_arm && (w_len != '0)
                 && (w_mode || sync_flag_i);
        w_wr   = 1'b0;
        w_last = 1'b0;
        if (w_trig) begin
            w_wr   = 1'b1;
            w_last = (w_len == FLW'(1));
        end else if (r_state == S_CAPT) begin
            w_wr   = 1'b1;
            w_last = (r_cnt == w_last_idx);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_s1_a <= '0;
            r_s1_b <= '0;
            r_s2   <= '0;
        end else if (w_srst) begin
            r_s1_a <= '0;
            r_s1_b <= '0;
            r_s2   <= '0;
        end else begin
            r_s1_a <= adc_dat_a;
            r_s1_b <= adc_dat_b;
            r_s2   <= {f_conv(r_s1_b), f_conv(r_s1_a)};
        end
    end

    // arm history resets high so a level held through reset is not an edge
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_arm_q <= 1'b1;
            r_rise  <= 1'b0;
        end else if (w_srst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_arm_q <= 1'b1;
            r_rise  <= 1'b0;
        end else begin
            r_arm_q <= w_arm;
            r_rise  <= w_arm & ~r_arm_q;
            case (r_state)
                S_IDLE: begin
                    if (r_rise) r_state <= S_ARMED;
                end
                S_ARMED: begin
                    if (!w_arm) begin
                        r_state <= S_IDLE;
                    end else if (w_len == '0) begin
                        r_state <= S_DONE;
                    end else if (w_trig) begin
                        r_cnt   <= FLW'(1);
                        r_state <= w_last ? S_DONE : S_CAPT;
                    end
                end
                S_CAPT: begin
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + FLW'(1);
                    end
                end
                S_DONE: begin
                    if (!w_arm) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    logic [AXIS_TDATA_WIDTH:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]               r_wp;
    logic [AW-1:0]               r_rp;
    logic [CW-1:0]               r_mcnt;
    logic [CW-1:0]               r_occ;
    logic                        r_out_v;
    logic [AXIS_TDATA_WIDTH-1:0] r_out_d;
    logic                        r_out_l;
    logic                        r_ovf;

    logic w_pop;
    logic w_full;
    logic w_acc;
    logic w_load;

    // occupancy counts the output register too, so capacity is FIFO_DEPTH
    assign w_pop  = r_out_v & m_axis_tready;
    assign w_full = (r_occ == CW'(FIFO_DEPTH));
    assign w_acc  = w_wr & (~w_full | w_pop);
    assign w_load = (r_mcnt != '0) & (~r_out_v | w_pop);

    always_ff @(posedge aclk) begin
        if (w_acc) r_mem[r_wp] <= {w_last, r_s2};
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_mcnt  <= '0;
            r_occ   <= '0;
            r_out_v <= 1'b0;
            r_out_d <= '0;
            r_out_l <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_srst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_mcnt  <= '0;
            r_occ   <= '0;
            r_out_v <= 1'b0;
            r_out_d <= '0;
            r_out_l <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_acc) r_wp <= r_wp + AW'(1);
            if (w_load) begin
                r_rp    <= r_rp + AW'(1);
                r_out_v <= 1'b1;
                r_out_d <= r_mem[r_rp][AXIS_TDATA_WIDTH-1:0];
                r_out_l <= r_mem[r_rp][AXIS_TDATA_WIDTH];
            end else if (w_pop) begin
                r_out_v <= 1'b0;
            end
            r_mcnt <= r_mcnt + CW'(w_acc) - CW'(w_load);
            r_occ  <= r_occ + CW'(w_acc) - CW'(w_pop);
            if (w_wr && !w_acc) r_ovf <= 1'b1;
        end
    end

    assign adc_csn       = 1'b1;
    assign m_axis_tvalid = r_out_v;
    assign m_axis_tdata  = r_out_d;
    assign m_axis_tlast  = r_out_l;
    assign rx_status_o   = {
        (r_occ == '0),
        r_ovf,
        (r_state == S_DONE),
        (r_state == S_ARMED) || (r_state == S_CAPT)
    };

endmodule

// File: tb/tb_axis_red_pitaya_adc_capture.sv
// Scoreboard bench: frame/FIFO reference model feeds an expected queue,
// a monitor pops and compares on every stream handshake.
module tb_axis_red_pitaya_adc_capture;

    localparam int DEPTH = 16;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [13:0] adc_a;
    logic [13:0] adc_b;
    logic        adc_csn;
    logic        sync;
    logic [31:0] cfg;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic [3:0]  status;

    always #5 aclk = ~aclk;

    axis_red_pitaya_adc_capture #(
        .ADC_DATA_WIDTH  (14),
        .AXIS_TDATA_WIDTH(32),
        .FRAME_LEN_WIDTH (16),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .adc_dat_a    (adc_a),
        .adc_dat_b    (adc_b),
        .adc_csn      (adc_csn),
        .sync_flag_i  (sync),
        .rx_cfg_i     (cfg),
        .m_axis_tdata (tdata),
        .m_axis_tvalid(tvalid),
        .m_axis_tready(tready),
        .m_axis_tlast (tlast),
        .rx_status_o  (status)
    );

    typedef struct {
        int unsigned wt;
        logic [31:0] d;
        logic        l;
    } ent_t;

    ent_t fq[$];
    ent_t expq[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] cw(input int n, input bit mode,
                                       input bit arm, input bit srst);
        return {13'd0, srst, mode, arm, 16'(n)};
    endfunction

    // inverted-magnitude code: value = 8191 - raw, as a signed 16-bit word
    function automatic logic [15:0] conv(input logic [13:0] raw);
        int v;
        v = 8191 - int'(raw);
        return 16'(v);
    endfunction

    int          drv_mode = 0;
    logic [13:0] ramp = '0;
    logic [13:0] codes [4];

    initial begin
        int sel;
        codes[0] = 14'h0000;
        codes[1] = 14'h1FFF;
        codes[2] = 14'h2000;
        codes[3] = 14'h3FFF;
        adc_a = '0;
        adc_b = '0;
        forever begin
            @(negedge aclk);
            sel = int'($urandom % 8);
            adc_a = (sel < 4) ? codes[sel] : 14'($urandom);
            if (drv_mode == 1) begin
                adc_b = ramp;
                ramp  = ramp + 14'd1;
            end else begin
                adc_b = 14'($urandom);
            end
        end
    end

    // reference model: evaluates the edge that follows each negedge
    int unsigned t = 0;
    logic        m_prev_arm, m_rise, m_ovf;
    int          m_phase, m_rem;
    logic [13:0] m_s1a, m_s1b;
    logic [31:0] m_s2;
    logic [3:0]  m_st;

    task automatic model_reset();
        m_prev_arm = 1'b1;
        m_rise     = 1'b0;
        m_ovf      = 1'b0;
        m_phase    = 0;
        m_rem      = 0;
        m_s1a      = '0;
        m_s1b      = '0;
        m_s2       = '0;
        m_st       = 4'b1000;
        fq.delete();
        expq.delete();
    endtask

    initial begin
        bit   vis, pop, wr, last, acc, arm, mode;
        int   n, pre;
        ent_t e;
        model_reset();
        forever begin
            @(negedge aclk);
            #1;
            t++;
            if (!aresetn) begin
                model_reset();
                check("rst_status", 32'(status), 32'h8);
                check("rst_valid", 32'(tvalid), 32'h0);
                continue;
            end
            vis = (fq.size() > 0) && (fq[0].wt + 2 <= t);
            check("tvalid", 32'(tvalid), 32'(vis));
            check("status", 32'(status), 32'(m_st));
            if (cfg[18]) begin
                model_reset();
                continue;
            end
            arm  = cfg[16];
            mode = cfg[17];
            n    = int'(cfg[15:0]);
            pop  = vis && tready;
            wr   = 1'b0;
            last = 1'b0;
            pre  = m_phase;
            if (pre == 0) begin
                if (m_rise) m_phase = 1;
            end else if (pre == 1) begin
                if (!arm) m_phase = 0;
                else if (n == 0) m_phase = 3;
                else if (mode || sync) begin
                    m_phase = 2;
                    m_rem   = n;
                end
            end else if (pre == 3) begin
                if (!arm) m_phase = 0;
            end
            if (m_phase == 2) begin
                wr    = 1'b1;
                last  = (m_rem == 1);
                m_rem = m_rem - 1;
                if (m_rem == 0) m_phase = 3;
            end
            acc = wr && ((fq.size() < DEPTH) || pop);
            if (wr && !acc) m_ovf = 1'b1;
            if (pop) void'(fq.pop_front());
            if (acc) begin
                e.wt = t;
                e.d  = m_s2;
                e.l  = last;
                fq.push_back(e);
                expq.push_back(e);
            end
            m_s2       = {conv(m_s1b), conv(m_s1a)};
            m_s1a      = adc_a;
            m_s1b      = adc_b;
            m_rise     = arm && !m_prev_arm;
            m_prev_arm = arm;
            m_st = {fq.size() == 0, m_ovf, m_phase == 3,
                    (m_phase == 1) || (m_phase == 2)};
        end
    end

    // monitor: pops the scoreboard on each handshake, checks stall hold
    initial begin
        bit          hv;
        logic [31:0] hd;
        logic        hl;
        ent_t        e;
        hv = 1'b0;
        forever begin
            @(negedge aclk);
            #1;
            if (!aresetn || cfg[18]) begin
                hv = 1'b0;
                continue;
            end
            if (hv) begin
                check("hold_valid", 32'(tvalid), 32'h1);
                check("hold_data", tdata, hd);
                check("hold_last", 32'(tlast), 32'(hl));
            end
            hv = 1'b0;
            if (tvalid && tready) begin
                if (expq.size() == 0) begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL unexpected_word: got %h want none", tdata);
                end else begin
                    e = expq.pop_front();
                    check("tdata", tdata, e.d);
                    check("tlast", 32'(tlast), 32'(e.l));
                end
            end else if (tvalid) begin
                hv = 1'b1;
                hd = tdata;
                hl = tlast;
            end
        end
    end

    initial begin
        aresetn = 1'b0;
        cfg     = '0;
        sync    = 1'b0;
        tready  = 1'b1;
        repeat (3) @(negedge aclk);
        check("rst_tvalid", 32'(tvalid), 32'h0);
        check("rst_tlast", 32'(tlast), 32'h0);
        check("rst_tdata", tdata, 32'h0);
        check("rst_stat", 32'(status), 32'h8);
        check("rst_csn", 32'(adc_csn), 32'h1);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);

        cfg = cw(4, 1, 1, 0);
        repeat (12) @(negedge aclk);
        check("t1_done", 32'(status[1:0]), 32'h2);
        cfg = cw(4, 1, 0, 0);
        repeat (3) @(negedge aclk);

        cfg = cw(8, 0, 1, 0);
        repeat (20) @(negedge aclk);
        check("t2_busy", 32'(status[1:0]), 32'h1);
        drv_mode = 1;
        sync = 1'b1;
        @(negedge aclk);
        sync = 1'b0;
        repeat (20) @(negedge aclk);
        check("t2_done", 32'(status[1:0]), 32'h2);
        drv_mode = 0;
        cfg = cw(8, 0, 0, 0);
        repeat (3) @(negedge aclk);

        tready = 1'b0;
        cfg = cw(40, 1, 1, 0);
        repeat (30) @(negedge aclk);
        tready = 1'b1;
        repeat (60) @(negedge aclk);
        check("t3_ovf", 32'(status[2]), 32'h1);
        cfg = cw(40, 1, 0, 0);
        repeat (3) @(negedge aclk);
        check("t3_ovf_sticky", 32'(status[2]), 32'h1);
        tready = 1'b0;
        cfg = cw(0, 0, 0, 1);
        repeat (2) @(negedge aclk);
        cfg = '0;
        tready = 1'b1;
        @(negedge aclk);
        check("t3_srst", 32'(status), 32'h8);

        cfg = cw(5, 1, 1, 0);
        repeat (30) begin
            @(negedge aclk);
            tready = ~tready;
        end
        tready = 1'b1;
        cfg = cw(5, 1, 0, 0);
        repeat (3) @(negedge aclk);

        cfg = cw(8, 0, 1, 0);
        repeat (5) @(negedge aclk);
        cfg = cw(8, 0, 0, 0);
        repeat (3) @(negedge aclk);
        check("t5_abort", 32'(status), 32'h8);
        cfg = cw(0, 1, 1, 0);
        repeat (5) @(negedge aclk);
        check("t5_n0", 32'(status), 32'hA);
        cfg = cw(0, 1, 0, 0);
        repeat (3) @(negedge aclk);
        cfg = cw(10, 1, 1, 0);
        repeat (5) @(negedge aclk);
        cfg = cw(10, 1, 0, 0);
        repeat (20) @(negedge aclk);
        check("t5_midfall", 32'(status), 32'h8);

        cfg = cw(10, 1, 1, 0);
        repeat (5) @(negedge aclk);
        aresetn = 1'b0;
        #1;
        check("t6_tvalid", 32'(tvalid), 32'h0);
        check("t6_tlast", 32'(tlast), 32'h0);
        check("t6_tdata", tdata, 32'h0);
        check("t6_stat", 32'(status), 32'h8);
        check("t6_csn", 32'(adc_csn), 32'h1);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        repeat (10) @(negedge aclk);
        check("t6_idle", 32'(status), 32'h8);
        cfg = cw(10, 1, 0, 0);
        @(negedge aclk);
        cfg = cw(12, 0, 1, 0);
        repeat (4) @(negedge aclk);
        sync = 1'b1;
        @(negedge aclk);
        sync = 1'b0;
        repeat (40) begin
            @(negedge aclk);
            tready = ($urandom % 3) != 0;
            sync   = ($urandom % 5) == 0;
        end
        sync = 1'b0;
        tready = 1'b1;
        cfg = cw(12, 0, 0, 0);
        repeat (30) @(negedge aclk);
        check("drained", 32'(expq.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
